// File: rtl/vita_sample_framer.sv
// Buffers one packet of timestamped samples, then emits the VITA-49 header, stream ID, tics and payload as 36-bit words.
// Samples are accepted only while filling. Each output word is held until dst_rdy_i is seen.
module vita_sample_framer #(
  parameter int BASE   = 0,
  parameter int BUF_AW = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [31:0] sample,
  input  logic [63:0] sample_time,
  input  logic        sample_sob,
  input  logic        sample_eob,
  input  logic        sample_src_rdy_i,
  output logic        sample_dst_rdy_o,
  output logic [35:0] data_o,
  output logic        src_rdy_o,
  input  logic        dst_rdy_i,
  output logic [3:0]  current_seqnum
);

  localparam int CW    = BUF_AW + 1;
  localparam int DEPTH = 1 << BUF_AW;

  typedef enum logic [2:0] {
    S_FILL, S_HEADER, S_STREAMID, S_TICS_HI, S_TICS_LO, S_PAYLOAD
  } state_t;

  state_t         state_q;
  logic [31:0]    sid_q;
  logic [15:0]    spp_q;
  logic [CW-1:0]  spp_lat_q;
  logic [CW-1:0]  count_q;
  logic [CW-1:0]  n_q;
  logic [CW-1:0]  rd_q;
  logic [63:0]    time_q;
  logic           sob_q;
  logic           eob_q;
  logic [3:0]     seqnum_q;
  logic [31:0]    pbuf_q [DEPTH];

  logic [CW-1:0]  spp_eff;
  logic [CW-1:0]  limit_d;
  logic [CW-1:0]  count_d;
  logic           accept_d;
  logic           close_d;
  logic           last_d;
  logic [31:0]    hdr_d;

  // The effective spp is clamped to the buffer depth; zero means one sample.
  always_comb begin
    if (spp_q == 16'd0) begin
      spp_eff = CW'(1);
    end else if (int'(spp_q) > DEPTH) begin
      spp_eff = CW'(DEPTH);
    end else begin
      spp_eff = CW'(spp_q);
    end
  end

  assign accept_d = (state_q == S_FILL) && sample_src_rdy_i;
  assign count_d  = count_q + CW'(1);
  assign limit_d  = (count_q == '0) ? spp_eff : spp_lat_q;
  assign close_d  = sample_eob || (count_d == limit_d);
  assign last_d   = (rd_q == n_q - CW'(1));
  assign hdr_d    = {4'b0001, 1'b0, 1'b0, sob_q, eob_q, 2'b00, 2'b01, seqnum_q,
                     16'(n_q) + 16'd4};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sid_q <= '0;
      spp_q <= 16'd16;
    end else if (set_stb) begin
      if (set_addr == 8'(BASE))     sid_q <= set_data;
      if (set_addr == 8'(BASE + 1)) spp_q <= set_data[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (accept_d && !clear) pbuf_q[count_q[BUF_AW-1:0]] <= sample;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FILL;
      spp_lat_q <= '0;
      count_q   <= '0;
      n_q       <= '0;
      rd_q      <= '0;
      time_q    <= '0;
      sob_q     <= 1'b0;
      eob_q     <= 1'b0;
      seqnum_q  <= '0;
    end else if (clear) begin
      state_q  <= S_FILL;
      count_q  <= '0;
      rd_q     <= '0;
      seqnum_q <= '0;
    end else begin
      case (state_q)
        S_FILL: begin
          if (accept_d) begin
            count_q <= count_d;
            if (count_q == '0) begin
              spp_lat_q <= spp_eff;
              time_q    <= sample_time;
              sob_q     <= sample_sob;
            end
            if (close_d) begin
              n_q     <= count_d;
              eob_q   <= sample_eob;
              state_q <= S_HEADER;
            end
          end
        end
        S_HEADER:   if (dst_rdy_i) state_q <= S_STREAMID;
        S_STREAMID: if (dst_rdy_i) state_q <= S_TICS_HI;
        S_TICS_HI:  if (dst_rdy_i) state_q <= S_TICS_LO;
        S_TICS_LO:  if (dst_rdy_i) state_q <= S_PAYLOAD;
        S_PAYLOAD: begin
          if (dst_rdy_i) begin
            if (last_d) begin
              seqnum_q <= seqnum_q + 4'd1;
              count_q  <= '0;
              rd_q     <= '0;
              state_q  <= S_FILL;
            end else begin
              rd_q <= rd_q + CW'(1);
            end
          end
        end
        default: state_q <= S_FILL;
      endcase
    end
  end

  always_comb begin
    data_o = '0;
    case (state_q)
      S_HEADER:   data_o = {2'b00, 1'b0, 1'b1, hdr_d};
      S_STREAMID: data_o = {4'b0000, sid_q};
      S_TICS_HI:  data_o = {4'b0000, time_q[63:32]};
      S_TICS_LO:  data_o = {4'b0000, time_q[31:0]};
      S_PAYLOAD:  data_o = {2'b00, last_d, 1'b0, pbuf_q[rd_q[BUF_AW-1:0]]};
      default:    data_o = '0;
    endcase
  end

  assign sample_dst_rdy_o = (state_q == S_FILL);
  assign src_rdy_o        = (state_q != S_FILL);
  assign current_seqnum   = seqnum_q;

endmodule

// File: tb/tb_vita_sample_framer.sv
// Directed bench for vita_sample_framer: packet layout, eob close, seqnum wrap, output stalls, spp clamping, clear.
module tb_vita_sample_framer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = '0;
  logic [31:0] set_data = '0;
  logic [31:0] sample = '0;
  logic [63:0] sample_time = '0;
  logic        sample_sob = 1'b0;
  logic        sample_eob = 1'b0;
  logic        sample_src_rdy_i = 1'b0;
  logic        sample_dst_rdy_o;
  logic [35:0] data_o;
  logic        src_rdy_o;
  logic        dst_rdy_i = 1'b0;
  logic [3:0]  current_seqnum;

  int          nvec = 0;
  int          nerr = 0;
  logic [35:0] got[$];
  logic [35:0] exp_q[$];
  logic [3:0]  exp_seq = '0;
  logic [31:0] sid = 32'hDEADBEEF;

  always #5 clk = ~clk;

  vita_sample_framer #(.BASE(0), .BUF_AW(9)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .sample(sample), .sample_time(sample_time),
    .sample_sob(sample_sob), .sample_eob(sample_eob),
    .sample_src_rdy_i(sample_src_rdy_i), .sample_dst_rdy_o(sample_dst_rdy_o),
    .data_o(data_o), .src_rdy_o(src_rdy_o), .dst_rdy_i(dst_rdy_i),
    .current_seqnum(current_seqnum)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d words pending", got.size());
    $fatal(1);
  end

  function automatic logic [31:0] hdr(input bit sob, input bit eob, input logic [3:0] seq, input int n);
    return {4'b0001, 1'b0, 1'b0, sob, eob, 2'b00, 2'b01, seq, 16'(n + 4)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_reg(input logic [7:0] a, input logic [31:0] d);
    set_stb = 1'b1; set_addr = a; set_data = d;
    tick;
    set_stb = 1'b0;
  endtask

  task automatic do_clear;
    clear = 1'b1;
    tick;
    clear = 1'b0;
    exp_seq = '0;
  endtask

  task automatic send(input int n, input logic [31:0] base, input logic [63:0] t,
                      input bit sob, input int eob_at);
    for (int i = 0; i < n; i++) begin
      int g = 0;
      while (!sample_dst_rdy_o && g < 1000) begin
        tick;
        g++;
      end
      sample           = base + 32'(i);
      sample_time      = t + 64'(i);
      sample_sob       = (i == 0) ? sob : 1'b0;
      sample_eob       = (i == eob_at);
      sample_src_rdy_i = 1'b1;
      tick;
    end
    sample_src_rdy_i = 1'b0;
    sample_sob       = 1'b0;
    sample_eob       = 1'b0;
  endtask

  task automatic build_exp(input bit sob, input bit eob, input logic [3:0] seq,
                           input logic [63:0] t, input logic [31:0] base, input int n);
    exp_q.delete();
    exp_q.push_back({4'b0001, hdr(sob, eob, seq, n)});
    exp_q.push_back({4'b0000, sid});
    exp_q.push_back({4'b0000, t[63:32]});
    exp_q.push_back({4'b0000, t[31:0]});
    for (int i = 0; i < n; i++) exp_q.push_back({2'b00, (i == n - 1), 1'b0, base + 32'(i)});
  endtask

  task automatic collect(input int nw);
    got.delete();
    dst_rdy_i = 1'b1;
    for (int c = 0; c < nw + 20 && got.size() < nw; c++) begin
      if (src_rdy_o) got.push_back(data_o);
      tick;
    end
    dst_rdy_i = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    nvec++; if (sample_dst_rdy_o !== 1'b1 || src_rdy_o !== 1'b0) begin nerr++;
      $display("FAIL reset_rdy: dst_rdy=%b src_rdy=%b, want 1/0", sample_dst_rdy_o, src_rdy_o); end
    reset = 1'b0;
    tick;
    nvec++; if (data_o !== 36'h0) begin nerr++;
      $display("FAIL reset_data: %h, want 0", data_o); end
    nvec++; if (current_seqnum !== 4'd0) begin nerr++;
      $display("FAIL reset_seq: %0d, want 0", current_seqnum); end
  endtask

  task automatic test_basic;
    set_reg(8'd0, sid);
    set_reg(8'd1, 32'd4);
    send(4, 32'h1, 64'h0000_0001_0000_0010, 1'b1, -1);
    nvec++; if (src_rdy_o !== 1'b1 || sample_dst_rdy_o !== 1'b0) begin nerr++;
      $display("FAIL basic_hdr_timing: src_rdy=%b dst_rdy=%b, want 1/0", src_rdy_o, sample_dst_rdy_o); end
    build_exp(1'b1, 1'b0, exp_seq, 64'h0000_0001_0000_0010, 32'h1, 4);
    collect(8);
    nvec++; if (got.size() != exp_q.size()) begin nerr++;
      $display("FAIL basic_count: %0d words, want %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      nvec++; if (i >= got.size() || got[i] !== exp_q[i]) begin nerr++;
        $display("FAIL basic_word%0d: %h, want %h", i, (i < got.size()) ? got[i] : 36'hx, exp_q[i]); end
    end
    exp_seq++;
    nvec++; if (current_seqnum !== exp_seq || sample_dst_rdy_o !== 1'b1) begin nerr++;
      $display("FAIL basic_after: seq=%0d dst_rdy=%b, want %0d/1", current_seqnum, sample_dst_rdy_o, exp_seq); end
  endtask

  task automatic test_eob;
    do_clear;
    set_reg(8'd1, 32'd10);
    send(3, 32'h100, 64'h55, 1'b0, 2);
    build_exp(1'b0, 1'b1, exp_seq, 64'h55, 32'h100, 3);
    collect(7);
    for (int i = 0; i < exp_q.size(); i++) begin
      nvec++; if (i >= got.size() || got[i] !== exp_q[i]) begin nerr++;
        $display("FAIL eob_word%0d: %h, want %h", i, (i < got.size()) ? got[i] : 36'hx, exp_q[i]); end
    end
    exp_seq++;
    send(10, 32'h200, 64'h99, 1'b0, -1);
    build_exp(1'b0, 1'b0, exp_seq, 64'h99, 32'h200, 10);
    collect(14);
    for (int i = 0; i < exp_q.size(); i++) begin
      nvec++; if (i >= got.size() || got[i] !== exp_q[i]) begin nerr++;
        $display("FAIL eob_next_word%0d: %h, want %h", i, (i < got.size()) ? got[i] : 36'hx, exp_q[i]); end
    end
    exp_seq++;
  endtask

  task automatic test_back_to_back;
    do_clear;
    set_reg(8'd1, 32'd4);
    for (int p = 0; p < 17; p++) begin
      send(4, 32'(p * 16), 64'(p * 1000), 1'b0, -1);
      build_exp(1'b0, 1'b0, exp_seq, 64'(p * 1000), 32'(p * 16), 4);
      collect(8);
      for (int i = 0; i < exp_q.size(); i++) begin
        nvec++; if (i >= got.size() || got[i] !== exp_q[i]) begin nerr++;
          $display("FAIL b2b_p%0d_word%0d: %h, want %h", p, i, (i < got.size()) ? got[i] : 36'hx, exp_q[i]); end
      end
      exp_seq++;
    end
    nvec++; if (current_seqnum !== 4'd1) begin nerr++;
      $display("FAIL b2b_wrap_seq: %0d, want 1", current_seqnum); end
  endtask

  task automatic test_stall;
    logic        prev_stall;
    logic [35:0] prev_dat;
    send(4, 32'hA0, 64'h1234_5678_9ABC_DEF0, 1'b1, -1);
    build_exp(1'b1, 1'b0, exp_seq, 64'h1234_5678_9ABC_DEF0, 32'hA0, 4);
    got.delete();
    prev_stall = 1'b0;
    prev_dat   = '0;
    for (int c = 0; c < 400 && got.size() < 8; c++) begin
      if (prev_stall) begin
        nvec++; if (src_rdy_o !== 1'b1 || data_o !== prev_dat) begin nerr++;
          $display("FAIL stall_hold: src_rdy=%b data=%h, want 1/%h", src_rdy_o, data_o, prev_dat); end
      end
      dst_rdy_i = ($urandom_range(3) == 0);
      if (src_rdy_o && dst_rdy_i) got.push_back(data_o);
      prev_stall = src_rdy_o && !dst_rdy_i;
      prev_dat   = data_o;
      tick;
    end
    dst_rdy_i = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      nvec++; if (i >= got.size() || got[i] !== exp_q[i]) begin nerr++;
        $display("FAIL stall_word%0d: %h, want %h", i, (i < got.size()) ? got[i] : 36'hx, exp_q[i]); end
    end
    exp_seq++;
  endtask

  task automatic test_spp_bounds;
    set_reg(8'd1, 32'd0);
    send(1, 32'h77, 64'h42, 1'b0, -1);
    build_exp(1'b0, 1'b0, exp_seq, 64'h42, 32'h77, 1);
    collect(5);
    for (int i = 0; i < exp_q.size(); i++) begin
      nvec++; if (i >= got.size() || got[i] !== exp_q[i]) begin nerr++;
        $display("FAIL spp0_word%0d: %h, want %h", i, (i < got.size()) ? got[i] : 36'hx, exp_q[i]); end
    end
    exp_seq++;
    set_reg(8'd1, 32'h0000_FFFF);
    send(512, 32'h1000, 64'h7, 1'b0, -1);
    nvec++; if (sample_dst_rdy_o !== 1'b0) begin nerr++;
      $display("FAIL sppmax_close: dst_rdy=%b, want 0", sample_dst_rdy_o); end
    build_exp(1'b0, 1'b0, exp_seq, 64'h7, 32'h1000, 512);
    collect(516);
    nvec++; if (got.size() != 516) begin nerr++;
      $display("FAIL sppmax_count: %0d words, want 516", got.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      nvec++; if (i >= got.size() || got[i] !== exp_q[i]) begin nerr++;
        $display("FAIL sppmax_word%0d: %h, want %h", i, (i < got.size()) ? got[i] : 36'hx, exp_q[i]); end
    end
    exp_seq++;
  endtask

  task automatic test_clear;
    set_reg(8'd1, 32'd4);
    send(4, 32'h300, 64'h88, 1'b0, -1);
    dst_rdy_i = 1'b1;
    for (int i = 0; i < 5; i++) tick;
    nvec++; if (data_o !== {4'b0000, 32'h301}) begin nerr++;
      $display("FAIL clear_pre: %h, want %h", data_o, {4'b0000, 32'h301}); end
    do_clear;
    dst_rdy_i = 1'b1;
    nvec++; if (src_rdy_o !== 1'b0 || sample_dst_rdy_o !== 1'b1 || current_seqnum !== 4'd0) begin nerr++;
      $display("FAIL clear_state: src_rdy=%b dst_rdy=%b seq=%0d, want 0/1/0",
               src_rdy_o, sample_dst_rdy_o, current_seqnum); end
    for (int i = 0; i < 4; i++) begin
      nvec++; if (src_rdy_o !== 1'b0) begin nerr++;
        $display("FAIL clear_no_eof%0d: src_rdy=%b data=%h, want idle", i, src_rdy_o, data_o); end
      tick;
    end
    dst_rdy_i = 1'b0;
    sample = 32'hBAD; sample_src_rdy_i = 1'b1;
    do_clear;
    sample_src_rdy_i = 1'b0;
    send(4, 32'h400, 64'h99, 1'b0, -1);
    build_exp(1'b0, 1'b0, exp_seq, 64'h99, 32'h400, 4);
    collect(8);
    for (int i = 0; i < exp_q.size(); i++) begin
      nvec++; if (i >= got.size() || got[i] !== exp_q[i]) begin nerr++;
        $display("FAIL clear_next_word%0d: %h, want %h", i, (i < got.size()) ? got[i] : 36'hx, exp_q[i]); end
    end
    exp_seq++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_eob;
    test_back_to_back;
    test_stall;
    test_spp_bounds;
    test_clear;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
